// File: rtl/msg_sched_ctrl.sv
// msg_sched_ctrl: SHA-256 message-schedule controller.
// Loads one 512-bit block as 16 big-endian words into a 16-entry circular
// buffer, then streams W[0..63]. Each expanded word W[t], t >= 16, is written
// back into the slot of W[t-16], so only 16 words are ever held.
// Optional build macro MSG_SCHED_ABORT_EN adds an 'abort' input that drops
// the current block and returns to LOAD.
module msg_sched_ctrl #(
  parameter int unsigned NWORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        w_valid,
  input  logic        w_ready,
`ifdef MSG_SCHED_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done
);

  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned TW    = 6;
  localparam logic [AW-1:0] LC_LAST = AW'(DEPTH - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(NWORDS - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   lc_q, lc_d;
  logic [TW-1:0]   t_q, t_d;
  logic            done_q, done_d;
  logic [WW-1:0]   wbuf_q [DEPTH];

  logic            abort_w;
  logic            expand;
  logic [AW-1:0]   a2, a7, a15, a16;
  logic [WW-1:0]   exp_word;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [WW-1:0]   wr_data;

`ifdef MSG_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [WW-1:0] sig0(input logic [WW-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WW-1:0] sig1(input logic [WW-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Circular-buffer taps for W[t-2], W[t-7], W[t-15], W[t-16]; 4-bit wrap is the mod-16
  assign a2  = t_q[AW-1:0] - 4'd2;
  assign a7  = t_q[AW-1:0] - 4'd7;
  assign a15 = t_q[AW-1:0] - 4'd15;
  assign a16 = t_q[AW-1:0];

  // Single-cycle expansion: two sigmas plus a 4-operand modular add
  assign expand   = |t_q[TW-1:AW];
  assign exp_word = sig1(wbuf_q[a2]) + wbuf_q[a7] + sig0(wbuf_q[a15]) + wbuf_q[a16];

  // Output decode from registered state/counters
  assign w_data   = expand ? exp_word : wbuf_q[a16];
  assign w_idx    = t_q;
  assign in_ready = (state_q == S_LOAD);
  assign w_valid  = (state_q == S_EMIT);
  assign busy     = (state_q == S_EMIT);
  assign done     = done_q;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      lc_q    <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load 16 words, emit 64, abort overrides any handshake
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    t_d     = t_q;
    done_d  = 1'b0;
    if (abort_w) begin
      state_d = S_LOAD;
      lc_d    = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            lc_d = lc_q + 4'd1;
            if (lc_q == LC_LAST) begin
              state_d = S_EMIT;
              lc_d    = '0;
              t_d     = '0;
            end
          end
        end
        S_EMIT: begin
          if (w_ready) begin
            if (t_q == T_LAST) begin
              state_d = S_LOAD;
              t_d     = '0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  // Buffer write port: message word in LOAD, expanded word write-back in EMIT
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = lc_q;
    wr_data = in_data;
    if (!abort_w) begin
      if (state_q == S_LOAD && in_valid) begin
        wr_en   = 1'b1;
        wr_addr = lc_q;
        wr_data = in_data;
      end else if (state_q == S_EMIT && w_ready && expand) begin
        wr_en   = 1'b1;
        wr_addr = a16;
        wr_data = exp_word;
      end
    end
  end

  // Buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      wbuf_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// tb_msg_sched_ctrl: scoreboard bench for msg_sched_ctrl. The reference
// schedule is the textbook SHA-256 expansion over a 64-entry array.
// Build with MSG_SCHED_ABORT_EN to include the abort scenario.
module tb_msg_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef MSG_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  msg_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
`ifdef MSG_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  logic [37:0] exp_q [$];
  logic [31:0] cur_m [16];
  logic [31:0] dut_w [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0m(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1m(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule for cur_m, queued as {index, word}
  task automatic push_model();
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = cur_m[t];
    for (int t = 16; t < 64; t++) w[t] = s1m(w[t-2]) + w[t-7] + s0m(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), w[t]});
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_w_valid",  32'(w_valid),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_w_idx",    32'(w_idx),    32'd0);
  endtask

  // Async reset asserted between edges; outputs must react immediately
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    in_valid = 1'b0;
    w_ready  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic load_block(input int reset_at_lc, input bit gaps, output bit ok);
    int acc = 0;
    int guard = 0;
    bit rdy;
    ok = 1'b0;
    while (acc < 16 && guard < 500) begin
      if (reset_at_lc >= 0 && acc == reset_at_lc) begin
        do_reset();
        return;
      end
      in_valid = gaps ? (($urandom % 3) != 0) : 1'b1;
      in_data  = cur_m[acc];
      rdy      = in_ready && in_valid;
      @(posedge clk); #1;
      guard++;
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    if (acc < 16) begin
      fail_now("load_timeout");
      return;
    end
    push_model();
    ok = 1'b1;
  endtask

  // Drive w_ready and stray in_valid pulses until done (or reset at w_idx)
  task automatic run_emit(input bit rnd, input int reset_at_t);
    int d0;
    d0 = done_cnt;
    for (int g = 0; g < 1000; g++) begin
      if (done) begin
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("done_count", 32'(done_cnt), 32'(d0 + 1));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        return;
      end
      if (reset_at_t >= 0 && w_valid && w_idx == 6'(reset_at_t)) begin
        do_reset();
        return;
      end
      w_ready  = rnd ? 1'($urandom % 2) : 1'b1;
      in_valid = w_valid ? 1'($urandom % 2) : 1'b0;
      in_data  = $urandom;
      @(posedge clk); #1;
    end
    fail_now("emit_timeout");
  endtask

`ifdef MSG_SCHED_ABORT_EN
  task automatic abort_emit(input int at);
    int d0;
    d0 = done_cnt;
    for (int g = 0; g < 1000; g++) begin
      if (w_valid && w_idx == 6'(at)) begin
        abort   = 1'b1;
        w_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_w_valid", 32'(w_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_w_idx", 32'(w_idx), 32'd0);
        exp_q.delete();
        @(negedge clk); #1;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        return;
      end
      w_ready = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    fail_now("abort_timeout");
  endtask
`endif

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    logic        prev_stall = 1'b0;
    logic        prev_last  = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [5:0]  prev_idx   = '0;
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_stall = 1'b0;
        prev_last  = 1'b0;
      end else begin
        chk("done_pulse", 32'(done), 32'(prev_last));
        if (done) done_cnt++;
        chk("in_ready", 32'(in_ready), 32'(!w_valid));
        chk("busy", 32'(busy), 32'(w_valid));
        if (prev_stall) begin
          chk("stall_valid", 32'(w_valid), 32'd1);
          chk("stall_data", w_data, prev_data);
          chk("stall_idx", 32'(w_idx), 32'(prev_idx));
        end
        if (w_valid && w_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_word");
          end else begin
            e = exp_q.pop_front();
            chk("w_idx", 32'(w_idx), 32'(e[37:32]));
            chk("w_data", w_data, e[31:0]);
          end
          dut_w[w_idx] = w_data;
        end
        prev_stall = w_valid && !w_ready;
        prev_last  = w_valid && w_ready && (w_idx == 6'd63);
        prev_data  = w_data;
        prev_idx   = w_idx;
      end
    end
  end

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_m[i] = 32'h0;
    cur_m[0]  = 32'h61626380;
    cur_m[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) cur_m[i] = $urandom;
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // "abc" block, no stalls
    set_abc();
    load_block(-1, 1'b0, ok);
    if (ok) run_emit(1'b0, -1);
    chk("abc_W16", dut_w[16], 32'h61626380);
    chk("abc_W17", dut_w[17], 32'h000F0000);
    chk("abc_W18", dut_w[18], 32'h7DA86405);
    chk("abc_W63", dut_w[63], 32'h12B1EDEB);

    // All-zero block with input gaps
    for (int i = 0; i < 16; i++) cur_m[i] = 32'h0;
    load_block(-1, 1'b1, ok);
    if (ok) run_emit(1'b0, -1);
    chk("zero_W63", dut_w[63], 32'h0);

    // Single sigma0 contribution
    for (int i = 0; i < 16; i++) cur_m[i] = 32'h0;
    cur_m[1] = 32'h0000FFFF;
    load_block(-1, 1'b0, ok);
    if (ok) run_emit(1'b0, -1);
    chk("m1_W16", dut_w[16], 32'hC1FFDE00);

    // "abc" with random back-pressure and stray inputs
    set_abc();
    load_block(-1, 1'b1, ok);
    if (ok) run_emit(1'b1, -1);
    chk("abc_stall_W18", dut_w[18], 32'h7DA86405);
    chk("abc_stall_W63", dut_w[63], 32'h12B1EDEB);

    // Reset mid-EMIT at t=30, then mid-LOAD at lc=7, then a clean block
    set_rand();
    load_block(-1, 1'b0, ok);
    if (ok) run_emit(1'b1, 30);
    set_rand();
    load_block(7, 1'b1, ok);
    set_abc();
    load_block(-1, 1'b1, ok);
    if (ok) run_emit(1'b1, -1);
    chk("post_reset_W63", dut_w[63], 32'h12B1EDEB);

    // Random blocks
    for (int b = 0; b < 4; b++) begin
      set_rand();
      load_block(-1, 1'b1, ok);
      if (ok) run_emit(1'b1, -1);
    end

`ifdef MSG_SCHED_ABORT_EN
    set_rand();
    load_block(-1, 1'b0, ok);
    if (ok) abort_emit(20);
    set_abc();
    load_block(-1, 1'b0, ok);
    if (ok) run_emit(1'b0, -1);
    chk("post_abort_W63", dut_w[63], 32'h12B1EDEB);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
